// File: rtl/rd_scheduler.sv
// rtl/rd_scheduler.sv - per-output round-robin burst read scheduler for the shared-memory switch
// Optional per-output 16-bit read counters on rd_cnt when RD_SCHED_CNT_EN is defined.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif

module rd_scheduler #(
   parameter int PORT_NUB  = `PORT_NUB_TOTAL,
   parameter int WIDTH_SEL = $clog2(PORT_NUB),
   parameter int MAX_BURST = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [PORT_NUB*PORT_NUB-1:0]    empty,
   input  logic [PORT_NUB-1:0]             tx_ready,
   output logic [WIDTH_SEL*PORT_NUB-1:0]   rd_sel,
   output logic [PORT_NUB-1:0]             rd_en,
   output logic [PORT_NUB-1:0]             data_valid,
   output logic [PORT_NUB-1:0]             grant_busy
`ifdef RD_SCHED_CNT_EN
   ,
   output logic [16*PORT_NUB-1:0]          rd_cnt
`endif
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   for (genvar o = 0; o < PORT_NUB; o++) begin : g_out
      typedef enum logic {IDLE, BURST} state_t;

      state_t                state;
      logic [WIDTH_SEL-1:0]  ptr;
      logic [WIDTH_SEL-1:0]  sel;
      logic [WIDTH_SEL-1:0]  winner;
      logic [WIDTH_SEL-1:0]  cand;
      logic [WIDTH_SEL-1:0]  next_ptr;
      logic [CNT_W-1:0]      burst_cnt;
      logic [PORT_NUB-1:0]   row;
      logic                  found;
      logic                  dv;
      logic                  en;
      int                    idx;

      assign row      = ~empty[o*PORT_NUB +: PORT_NUB];
      assign en       = (state == BURST) && row[sel] && tx_ready[o];
      assign next_ptr = (int'(sel) == PORT_NUB - 1) ? '0 : sel + 1'b1;

      // Scan from the highest offset down so the nearest non-empty queue after ptr wins.
      always_comb begin
         found  = 1'b0;
         winner = ptr;
         idx    = 0;
         cand   = '0;
         for (int k = PORT_NUB - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= PORT_NUB) idx = idx - PORT_NUB;
            cand = WIDTH_SEL'(idx);
            if (row[cand]) begin
               found  = 1'b1;
               winner = cand;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            sel       <= '0;
            burst_cnt <= '0;
            dv        <= 1'b0;
         end else begin
            dv <= en;
            case (state)
               IDLE: begin
                  if (found) begin
                     sel       <= winner;
                     burst_cnt <= '0;
                     state     <= BURST;
                  end
               end
               BURST: begin
                  if (!row[sel]) begin
                     state <= IDLE;
                     ptr   <= next_ptr;
                  end else if (en) begin
                     if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state <= IDLE;
                        ptr   <= next_ptr;
                     end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign rd_sel[o*WIDTH_SEL +: WIDTH_SEL] = sel;
      assign rd_en[o]      = en;
      assign data_valid[o] = dv;
      assign grant_busy[o] = (state == BURST);

`ifdef RD_SCHED_CNT_EN
      logic [15:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)     cnt <= '0;
         else if (en) cnt <= cnt + 16'd1;
      end

      assign rd_cnt[o*16 +: 16] = cnt;
`endif
   end

endmodule

// File: tb/tb_rd_scheduler.sv
// tb/tb_rd_scheduler.sv - self-checking bench for rd_scheduler (PORT_NUB=4, MAX_BURST=4)
// Counter checks are compiled in when RD_SCHED_CNT_EN is defined.
module tb_rd_scheduler;

   localparam int P  = 4;
   localparam int MB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] empty;
   logic [3:0]  tx_ready;
   logic [7:0]  rd_sel;
   logic [3:0]  rd_en;
   logic [3:0]  data_valid;
   logic [3:0]  grant_busy;
`ifdef RD_SCHED_CNT_EN
   logic [63:0] rd_cnt;
`endif

   int occ[4][4];
   int mptr[4];
   int tbcnt[4];
   int n_vec = 0;
   int n_err = 0;
   int exp_trace[4][$];
   int exp_bs[4][$];
   int exp_bl[4][$];
   int obs_bs[4][$];
   int obs_bl[4][$];

   rd_scheduler #(.PORT_NUB(P), .WIDTH_SEL(2), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .empty      (empty),
      .tx_ready   (tx_ready),
      .rd_sel     (rd_sel),
      .rd_en      (rd_en),
      .data_valid (data_valid),
      .grant_busy (grant_busy)
`ifdef RD_SCHED_CNT_EN
      ,
      .rd_cnt     (rd_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic update_empty();
      for (int o = 0; o < P; o++)
         for (int i = 0; i < P; i++)
            empty[o*P+i] = (occ[o][i] == 0);
   endtask

   // Transaction-level model: burst list and per-cycle trace (-1 idle, -2 drained, else reading input)
   task automatic build_expect();
      for (int o = 0; o < P; o++) begin
         int rem[4];
         int p;
         int w;
         int len;
         exp_trace[o].delete();
         exp_bs[o].delete();
         exp_bl[o].delete();
         obs_bs[o].delete();
         obs_bl[o].delete();
         for (int i = 0; i < P; i++) rem[i] = occ[o][i];
         p = mptr[o];
         forever begin
            w = -1;
            for (int k = 0; k < P; k++)
               if (w < 0 && rem[(p + k) % P] > 0) w = (p + k) % P;
            if (w < 0) break;
            exp_trace[o].push_back(-1);
            len = (rem[w] < MB) ? rem[w] : MB;
            for (int j = 0; j < len; j++) exp_trace[o].push_back(w);
            rem[w] -= len;
            if (len < MB) exp_trace[o].push_back(-2);
            exp_bs[o].push_back(w);
            exp_bl[o].push_back(len);
            p = (w + 1) % P;
         end
         mptr[o] = p;
      end
   endtask

   task automatic run_round(input bit exact, input bit bp, input int limit);
      int   cyc;
      int   maxlen;
      int   cur[4];
      int   last_sel[4];
      int   e;
      int   s;
      bit   done;
      logic [3:0] prev_en;
      logic [3:0] prev_gb;
      build_expect();
      cyc = 0;
      maxlen = 0;
      prev_en = '0;
      prev_gb = '0;
      for (int o = 0; o < P; o++) begin
         cur[o] = 0;
         last_sel[o] = 0;
         if (exp_trace[o].size() > maxlen) maxlen = exp_trace[o].size();
      end
      forever begin
         tx_ready = bp ? 4'($urandom) : 4'hF;
         #1;
         for (int o = 0; o < P; o++) begin
            s = int'(rd_sel[o*2 +: 2]);
            check("data_valid", data_valid[o], prev_en[o]);
            if (exact) begin
               e = (cyc < exp_trace[o].size()) ? exp_trace[o][cyc] : -1;
               check("rd_en", rd_en[o], e >= 0);
               if (e >= 0) check("rd_sel", s, e);
               check("grant_busy", grant_busy[o], e != -1);
            end
            if (rd_en[o] === 1'b1) begin
               check("no_underflow", tx_ready[o] && occ[o][s] > 0, 1);
               if (occ[o][s] > 0) occ[o][s]--;
               cur[o]++;
               tbcnt[o]++;
            end
            if (grant_busy[o] === 1'b1) last_sel[o] = s;
            if (prev_gb[o] && grant_busy[o] === 1'b0) begin
               obs_bs[o].push_back(last_sel[o]);
               obs_bl[o].push_back(cur[o]);
               cur[o] = 0;
            end
         end
         prev_en = rd_en;
         prev_gb = grant_busy;
         done = (grant_busy == 4'h0) && (!exact || cyc >= maxlen);
         for (int o = 0; o < P; o++)
            for (int i = 0; i < P; i++)
               if (occ[o][i] != 0) done = 1'b0;
         @(posedge clk);
         #1;
         update_empty();
         @(negedge clk);
         cyc++;
         if (done) break;
         if (cyc >= limit) begin
            check("round_timeout", 0, 1);
            break;
         end
      end
      for (int o = 0; o < P; o++) begin
         check("burst_count", obs_bs[o].size(), exp_bs[o].size());
         for (int j = 0; j < exp_bs[o].size() && j < obs_bs[o].size(); j++) begin
            check("burst_sel", obs_bs[o][j], exp_bs[o][j]);
            check("burst_len", obs_bl[o][j], exp_bl[o][j]);
         end
`ifdef RD_SCHED_CNT_EN
         check("rd_cnt", rd_cnt[o*16 +: 16], tbcnt[o] & 32'hFFFF);
`endif
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      for (int o = 0; o < P; o++) begin
         mptr[o]  = 0;
         tbcnt[o] = 0;
      end
   endtask

   initial begin
      int reads;
      rst = 1'b1;
      tx_ready = 4'hF;
      for (int o = 0; o < P; o++) begin
         mptr[o] = 0;
         tbcnt[o] = 0;
         for (int i = 0; i < P; i++) occ[o][i] = 0;
      end
      occ[0][1] = 3; occ[2][3] = 2; occ[3][0] = 5;
      update_empty();

      // reset held with queues non-empty
      repeat (4) begin
         @(negedge clk);
         #1;
         check("rst_rd_en", rd_en, 0);
         check("rst_rd_sel", rd_sel, 0);
         check("rst_data_valid", data_valid, 0);
         check("rst_grant_busy", grant_busy, 0);
`ifdef RD_SCHED_CNT_EN
         check("rst_rd_cnt", rd_cnt, 0);
`endif
      end
      @(negedge clk);
      rst = 1'b0;
      run_round(1, 0, 200);

      // single queue, then scan resumes after the last winner
      occ[0][2] = 3; update_empty(); run_round(1, 0, 200);
      occ[0][0] = 2; occ[0][3] = 2; update_empty(); run_round(1, 0, 200);

      // round robin between two inputs on output 1
      occ[1][0] = 10; occ[1][3] = 10; update_empty(); run_round(1, 0, 200);

      // all outputs in parallel, burst boundary at MAX_BURST
      for (int o = 0; o < P; o++) occ[o][1] = 5;
      update_empty(); run_round(1, 0, 200);

      // backpressure, directed then random
      occ[1][2] = 6; update_empty(); run_round(0, 1, 400);
      repeat (3) begin
         for (int o = 0; o < P; o++)
            for (int i = 0; i < P; i++) occ[o][i] = $urandom_range(0, 9);
         update_empty();
         run_round(0, 1, 2000);
      end

      // random occupancy with exact cycle timing
      repeat (4) begin
         for (int o = 0; o < P; o++)
            for (int i = 0; i < P; i++) occ[o][i] = $urandom_range(0, 9);
         update_empty();
         run_round(1, 0, 1000);
      end

      // reset in the middle of a burst
      occ[0][0] = 6; update_empty();
      reads = 0;
      for (int c = 0; c < 20 && reads < 2; c++) begin
         tx_ready = 4'hF;
         #1;
         if (rd_en[0] === 1'b1) begin
            occ[0][int'(rd_sel[1:0])]--;
            reads++;
         end
         @(posedge clk);
         #1;
         update_empty();
         @(negedge clk);
      end
      check("pre_reset_reads", reads, 2);
      rst = 1'b1;
      #1;
      check("midrst_rd_en", rd_en[0], 0);
      check("midrst_grant_busy", grant_busy[0], 0);
      check("midrst_data_valid", data_valid[0], 0);
`ifdef RD_SCHED_CNT_EN
      check("midrst_rd_cnt", rd_cnt[15:0], 0);
`endif
      @(negedge clk);
      do_reset(2);
      run_round(1, 0, 200);

`ifdef RD_SCHED_CNT_EN
      // counter wrap after 0x10000 reads
      @(negedge clk);
      do_reset(1);
      occ[0][0] = 65536; update_empty();
      run_round(0, 0, 90000);
      check("rd_cnt_wrap", rd_cnt[15:0], 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
